ifmap_stream_ctrl: RTL and testbench
====================================

// Module: ifmap_stream_ctrl
// PURPOSE
//  Parametrised ifmap fetch engine between the ifmap GLB and the PE-array multicast bus. Walks one
//  processing pass (s cols x q chans x H rows), issues GLB reads, and optionally synthesises zero-pad
//  words. Returns data plus {row,col} tag in scan order under valid/ready backpressure.
//  Credit-limited so no GLB word is dropped.
// PARAMETERS
//  DATA_W     16  ifmap word width
//  ADDR_W     16  GLB read-address width
//  GLB_LAT    2   GLB read latency (cycles, en -> rdata), >=1
//  FIFO_DEPTH 4   output FIFO entries; must be >= GLB_LAT+1 (elaboration-time $error otherwise)
//  ROW_TAG_W  4   row-tag width;  COL_TAG_W 5  col-tag width
// PORTS
//  i_clk          in   1          clock, rising edge
//  i_rst_n        in   1          asynchronous active-low reset
//  i_start        in   1          1-cycle pass start; ignored while o_busy
//  i_iter_cnt     in   6          window iteration index
//  i_layer_HW     in   8          ifmap height = width
//  i_layer_U      in   3          stride
//  i_layer_PAD    in   2          zero-pad size
//  i_layer_e      in   5          output rows per pass
//  i_layer_q      in   3          channels per pass, >=1
//  i_layer_s      in   4          filter width, >=1
//  i_c_base       in   8          first channel index of this pass
//  i_row_tag      in   ROW_TAG_W  row tag stamped on every word of the pass
//  i_pad_mode     in   1          0 = skip padded positions, 1 = emit zero words for them
//  o_busy         out  1          high from cycle after accepted start until o_done cycle inclusive
//  o_done         out  1          1-cycle pulse: last word of pass accepted downstream
//  o_glb_en       out  1          GLB read enable
//  o_glb_ra       out  ADDR_W     GLB read address
//  i_glb_rdata    in   DATA_W     GLB data, valid GLB_LAT cycles after o_glb_en
//  o_ifmap_valid  out  1          FIFO head valid
//  i_ifmap_ready  in   1          downstream accept; transfer = valid & ready
//  o_ifmap_data   out  DATA_W     ifmap word (0 for synthesised pad words)
//  o_ifmap_tag    out  ROW_TAG_W+COL_TAG_W  {i_row_tag, cnt_H+1}
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters/pipe/FIFO cleared. Reset mid-pass aborts; no o_done.
//  - FSM: IDLE -(i_start)-> SCAN -(last position issued)-> DRAIN -(pipe+FIFO empty)-> DONE -> IDLE.
//    o_done is asserted in the DONE cycle.
//  - Scan order: W fastest (0..s-1), then C (0..q-1), then H (0..last_row). Counters latch layer
//    inputs on start; inputs may change afterwards.
//    last_row = (e-1)*U + s-1.
//  - col = cnt_W + U*iter_cnt. Padded if cnt_H<PAD | cnt_H>=HW+PAD | col<PAD | col>=HW+PAD.
//    All compares are 9-bit unsigned.
//  - Address, truncated to ADDR_W = (c_base+cnt_C)*HW*HW + (cnt_H-PAD)*HW + (col-PAD).
//  - Credit: in_flight = words in latency pipe + FIFO count. A position advances only if
//    in_flight < FIFO_DEPTH. Skipped pad positions (mode 0) advance with no credit, 1 per cycle.
//  - Non-pad position: o_glb_en=1 combinationally with the counter state.
//  - Pad position, mode 1: o_glb_en=0. A zero word enters the same GLB_LAT delay line, so order
//    is preserved.
//  - Pipe tail pushes {data,tag} into FIFO. Push and pop in the same cycle is legal at any occupancy.
//  - Full throughput (1 word/cycle) when ready is held high.
//  - Zero-word pass (mode 0, every position padded): goes SCAN->DRAIN->DONE; o_done still pulses.
//  - Outputs hold stable while valid & !ready.
// STRUCTURE
//  - Shared package ifmap_pkg: FSM state enum; ifmap tag struct {row,col}; PAD_SKIP/PAD_EMIT constants.
//  - Sub-module ifmap_out_fifo (sync FIFO, DEPTH/WIDTH params, count output) holds {data,tag}.
//  - Delay line and scan counters stay in this module.
// TESTING
//  1. HW=8,U=1,PAD=0,e=2,q=1,s=3,iter=0,ready=1 -> 12 words.
//     Addrs r0:0,1,2  r1:8,9,10  r2:16,17,18  r3:24,25,26. Tags col 1..4. o_done 1 cycle after last.
//  2. Same cfg, PAD=1, mode 0 -> row0 and col0 skipped: 6 words (addrs 0,1,8,9,16,17).
//     Mode 1 -> 12 words, 6 of them zero, in scan order.
//  3. q=2, c_base=3, HW=4, s=1, e=1 -> addrs 48, 64. Tags carry i_row_tag.
//  4. ready=0 for 20 cycles mid-pass -> o_glb_en stops after FIFO_DEPTH outstanding.
//     No word lost or duplicated. Data/tag stable while stalled.
//  5. Random ready (50%), GLB_LAT=3, FIFO_DEPTH=4 -> output matches scoreboard. i_start while busy ignored.
//  6. i_rst_n low mid-DRAIN -> outputs 0 asynchronously, no o_done. A new start then runs a clean pass.

Source files
------------

// File: rtl/ifmap_pkg.sv
// Shared types and constants for the ifmap stream controller.
package ifmap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefRowTagW = 4;
  localparam int unsigned DefColTagW = 5;

  // Tag layout at the default widths: {row, col}
  typedef struct packed {
    logic [DefRowTagW-1:0] row;
    logic [DefColTagW-1:0] col;
  } ifmap_tag_t;

  localparam logic PAD_SKIP = 1'b0;
  localparam logic PAD_EMIT = 1'b1;

endpackage

// File: rtl/ifmap_out_fifo.sv
// Synchronous FIFO holding {data,tag} entries; push and pop may coincide at any occupancy.
module ifmap_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A pop frees the slot, so a push into a full FIFO is accepted in the same cycle.
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Head is forced to zero when empty so outputs are clean after reset.
  assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ifmap_stream_ctrl.sv
// Ifmap fetch engine: scans one pass, issues GLB reads or zero-pad words, and streams tagged
// words out through a credit-limited FIFO.
module ifmap_stream_ctrl
  import ifmap_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned GLB_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROW_TAG_W  = DefRowTagW,
  parameter int unsigned COL_TAG_W  = DefColTagW
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [5:0]                     i_iter_cnt,
  input  logic [7:0]                     i_layer_HW,
  input  logic [2:0]                     i_layer_U,
  input  logic [1:0]                     i_layer_PAD,
  input  logic [4:0]                     i_layer_e,
  input  logic [2:0]                     i_layer_q,
  input  logic [3:0]                     i_layer_s,
  input  logic [7:0]                     i_c_base,
  input  logic [ROW_TAG_W-1:0]           i_row_tag,
  input  logic                           i_pad_mode,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_glb_en,
  output logic [ADDR_W-1:0]              o_glb_ra,
  input  logic [DATA_W-1:0]              i_glb_rdata,
  output logic                           o_ifmap_valid,
  input  logic                           i_ifmap_ready,
  output logic [DATA_W-1:0]              o_ifmap_data,
  output logic [ROW_TAG_W+COL_TAG_W-1:0] o_ifmap_tag
);

  localparam int unsigned TAG_W   = ROW_TAG_W + COL_TAG_W;
  localparam int unsigned ENTRY_W = DATA_W + TAG_W;
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PCNT_W  = $clog2(GLB_LAT + 1);

  if ((GLB_LAT < 1) || (FIFO_DEPTH < GLB_LAT + 1)) begin : g_param_check
    $error("ifmap_stream_ctrl: need GLB_LAT >= 1 and FIFO_DEPTH >= GLB_LAT+1");
  end

  state_e state_q, state_d;

  // Pass configuration latched on start
  logic [5:0]           iter_q;
  logic [7:0]           hw_q;
  logic [2:0]           u_q;
  logic [1:0]           pad_q;
  logic [4:0]           e_q;
  logic [2:0]           q_q;
  logic [3:0]           s_q;
  logic [7:0]           c_base_q;
  logic [ROW_TAG_W-1:0] row_tag_q;
  logic                 pad_mode_q;

  logic [3:0] cnt_w_q;
  logic [2:0] cnt_c_q;
  logic [8:0] cnt_h_q;

  // Delay line mirroring the GLB read latency; zero flag marks synthesised pad words
  logic [GLB_LAT-1:0] pipe_vld_q;
  logic [GLB_LAT-1:0] pipe_zero_q;
  logic [TAG_W-1:0]   pipe_tag_q [GLB_LAT];
  logic [PCNT_W-1:0]  pipe_cnt;

  logic [8:0]        col, hw_end, last_row;
  logic              is_pad, last_w, last_c, last_h, last_pos;
  logic [ADDR_W-1:0] glb_addr;
  logic [TAG_W-1:0]  cur_tag;
  logic              credit_ok, drain_empty;
  logic              advance, issue, glb_en, done;

  logic              fifo_push, fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [FCNT_W-1:0] fifo_cnt;

  assign col      = 9'(cnt_w_q) + 9'(u_q) * 9'(iter_q);
  assign hw_end   = 9'(hw_q) + 9'(pad_q);
  assign last_row = (9'(e_q) - 9'd1) * 9'(u_q) + 9'(s_q) - 9'd1;
  assign is_pad   = (cnt_h_q < 9'(pad_q)) || (cnt_h_q >= hw_end) ||
                    (col < 9'(pad_q)) || (col >= hw_end);
  assign last_w   = (cnt_w_q == s_q - 4'd1);
  assign last_c   = (cnt_c_q == q_q - 3'd1);
  assign last_h   = (cnt_h_q == last_row);
  assign last_pos = last_w && last_c && last_h;

  // Wrapped subtractions only occur on padded positions, where the address is unused.
  assign glb_addr = ADDR_W'(9'(c_base_q) + 9'(cnt_c_q)) * ADDR_W'(hw_q) * ADDR_W'(hw_q) +
                    ADDR_W'(cnt_h_q - 9'(pad_q)) * ADDR_W'(hw_q) +
                    ADDR_W'(col - 9'(pad_q));
  assign cur_tag  = {row_tag_q, COL_TAG_W'(cnt_h_q + 9'd1)};

  // Words currently held in the delay line
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < GLB_LAT; i++) begin
      pipe_cnt = pipe_cnt + PCNT_W'(pipe_vld_q[i]);
    end
  end

  assign credit_ok   = (32'(pipe_cnt) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH);
  // Leave DRAIN as the final word is popped so o_done lands in the following cycle.
  assign drain_empty = (pipe_cnt == '0) &&
                       ((fifo_cnt == '0) || ((fifo_cnt == FCNT_W'(1)) && fifo_pop));

  // Next-state and per-position issue decision
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    issue   = 1'b0;
    glb_en  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StScan;
      end
      StScan: begin
        if (is_pad && (pad_mode_q != PAD_EMIT)) begin
          advance = 1'b1;
        end else if (credit_ok) begin
          advance = 1'b1;
          issue   = 1'b1;
          glb_en  = !is_pad;
        end
        if (advance && last_pos) state_d = StDrain;
      end
      StDrain: begin
        if (drain_empty) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Configuration latch and W/C/H scan counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iter_q     <= '0;
      hw_q       <= '0;
      u_q        <= '0;
      pad_q      <= '0;
      e_q        <= '0;
      q_q        <= '0;
      s_q        <= '0;
      c_base_q   <= '0;
      row_tag_q  <= '0;
      pad_mode_q <= PAD_SKIP;
      cnt_w_q    <= '0;
      cnt_c_q    <= '0;
      cnt_h_q    <= '0;
    end else if ((state_q == StIdle) && i_start) begin
      iter_q     <= i_iter_cnt;
      hw_q       <= i_layer_HW;
      u_q        <= i_layer_U;
      pad_q      <= i_layer_PAD;
      e_q        <= i_layer_e;
      q_q        <= i_layer_q;
      s_q        <= i_layer_s;
      c_base_q   <= i_c_base;
      row_tag_q  <= i_row_tag;
      pad_mode_q <= i_pad_mode;
      cnt_w_q    <= '0;
      cnt_c_q    <= '0;
      cnt_h_q    <= '0;
    end else if (advance) begin
      if (!last_w) begin
        cnt_w_q <= cnt_w_q + 4'd1;
      end else begin
        cnt_w_q <= '0;
        if (!last_c) begin
          cnt_c_q <= cnt_c_q + 3'd1;
        end else begin
          cnt_c_q <= '0;
          cnt_h_q <= cnt_h_q + 9'd1;
        end
      end
    end
  end

  // Latency-matched delay line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld_q  <= '0;
      pipe_zero_q <= '0;
      for (int i = 0; i < GLB_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_zero_q[0] <= is_pad;
      pipe_tag_q[0]  <= cur_tag;
      for (int i = 1; i < GLB_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_zero_q[i] <= pipe_zero_q[i-1];
        pipe_tag_q[i]  <= pipe_tag_q[i-1];
      end
    end
  end

  assign fifo_push  = pipe_vld_q[GLB_LAT-1];
  assign fifo_wdata = {(pipe_zero_q[GLB_LAT-1] ? {DATA_W{1'b0}} : i_glb_rdata),
                       pipe_tag_q[GLB_LAT-1]};
  assign fifo_pop   = o_ifmap_valid && i_ifmap_ready;

  ifmap_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_out_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt)
  );

  assign o_busy        = (state_q != StIdle);
  assign o_done        = done;
  assign o_glb_en      = glb_en;
  assign o_glb_ra      = glb_en ? glb_addr : '0;
  assign o_ifmap_valid = (fifo_cnt != '0);
  assign o_ifmap_data  = fifo_rdata[ENTRY_W-1:TAG_W];
  assign o_ifmap_tag   = fifo_rdata[TAG_W-1:0];

endmodule

// File: tb/tb_ifmap_stream_ctrl.sv
// Self-checking bench for ifmap_stream_ctrl with a GLB latency model and output scoreboard.
module tb_ifmap_stream_ctrl;
  import ifmap_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LAT = 3;
  localparam int DEPTH = 4;
  localparam int RTW = 4;
  localparam int CTW = 5;
  localparam int TW = RTW + CTW;

  logic          clk, rst_n, start;
  logic [5:0]    iter_cnt;
  logic [7:0]    layer_hw;
  logic [2:0]    layer_u;
  logic [1:0]    layer_pad;
  logic [4:0]    layer_e;
  logic [2:0]    layer_q;
  logic [3:0]    layer_s;
  logic [7:0]    c_base;
  logic [RTW-1:0] row_tag;
  logic          pad_mode;
  logic          busy, done, glb_en, ifmap_valid, ifmap_ready;
  logic [AW-1:0] glb_ra;
  logic [DW-1:0] glb_rdata, ifmap_data;
  logic [TW-1:0] ifmap_tag;

  ifmap_stream_ctrl #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .GLB_LAT    (LAT),
    .FIFO_DEPTH (DEPTH),
    .ROW_TAG_W  (RTW),
    .COL_TAG_W  (CTW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_iter_cnt    (iter_cnt),
    .i_layer_HW    (layer_hw),
    .i_layer_U     (layer_u),
    .i_layer_PAD   (layer_pad),
    .i_layer_e     (layer_e),
    .i_layer_q     (layer_q),
    .i_layer_s     (layer_s),
    .i_c_base      (c_base),
    .i_row_tag     (row_tag),
    .i_pad_mode    (pad_mode),
    .o_busy        (busy),
    .o_done        (done),
    .o_glb_en      (glb_en),
    .o_glb_ra      (glb_ra),
    .i_glb_rdata   (glb_rdata),
    .o_ifmap_valid (ifmap_valid),
    .i_ifmap_ready (ifmap_ready),
    .o_ifmap_data  (ifmap_data),
    .o_ifmap_tag   (ifmap_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB model: content is a fixed function of address, returned LAT cycles after the enable.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 16'd3) ^ 16'h5A00;
  endfunction

  logic [DW-1:0] glb_pipe [LAT];
  always @(posedge clk) begin
    glb_pipe[0] <= glb_en ? mem_word(glb_ra) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) glb_pipe[i] <= glb_pipe[i-1];
  end
  assign glb_rdata = glb_pipe[LAT-1];

  typedef struct {
    int hw, u, pad, e, q, s, iter, cb, rt, mode, rmode, exp_words, exp_addr0;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    bit            pad;
  } word_t;

  word_t wq[$];
  int    aq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0, pass_cyc = 0, rmode = 0;
  int recv, last_xfer, done_cyc, done_cnt, outstanding, en_cnt, first_addr;
  int stall_outstanding, stall_late_en, prev_data, prev_tag;
  bit stall_prev = 0, inject = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    recv = 0; last_xfer = -10; done_cyc = -10; done_cnt = 0; outstanding = 0;
    en_cnt = 0; first_addr = -1; stall_outstanding = -1; stall_late_en = 0;
    pass_cyc = 0; stall_prev = 0;
  endtask

  // One clock: drive ready, then sample and score outputs mid-cycle.
  task automatic step();
    word_t w;
    int a;
    @(posedge clk);
    #1;
    start = 1'b0;
    case (rmode)
      0: ifmap_ready = 1'b1;
      1: ifmap_ready = 1'($urandom % 2);
      2: ifmap_ready = !(pass_cyc >= 5 && pass_cyc < 25);
      default: ifmap_ready = 1'b0;
    endcase
    #1;
    if (stall_prev) begin
      check("stall_valid", int'(ifmap_valid), 1);
      check("stall_data", int'(ifmap_data), prev_data);
      check("stall_tag", int'(ifmap_tag), prev_tag);
    end
    if (glb_en) begin
      en_cnt++;
      outstanding++;
      if (en_cnt == 1) first_addr = int'(glb_ra);
      check("addr_expected", int'(aq.size() > 0), 1);
      if (aq.size() > 0) begin
        a = aq.pop_front();
        check("glb_ra", int'(glb_ra), a);
      end
      check("credit_limit", int'(outstanding <= DEPTH), 1);
      if (rmode == 2 && pass_cyc >= 15 && pass_cyc < 25) stall_late_en++;
    end
    if (ifmap_valid && ifmap_ready) begin
      check("word_expected", int'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        check("ifmap_data", int'(ifmap_data), int'(w.data));
        check("ifmap_tag", int'(ifmap_tag), int'(w.tag));
        if (!w.pad) outstanding--;
      end
      recv++;
      last_xfer = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    stall_prev = ifmap_valid && !ifmap_ready;
    prev_data  = int'(ifmap_data);
    prev_tag   = int'(ifmap_tag);
    if (rmode == 2 && pass_cyc == 24) stall_outstanding = outstanding;
    if (inject && pass_cyc == 10) begin
      start   = 1'b1;
      layer_s = 4'd1;
    end
    pass_cyc++;
    cyc++;
  endtask

  // Reference scan: expected addresses and output words in scan order.
  task automatic build_model(input vec_t v);
    int last_row, col, addr, hp1;
    bit pd;
    word_t w;
    logic [31:0] rtv;
    wq.delete();
    aq.delete();
    last_row = (v.e - 1) * v.u + v.s - 1;
    rtv = 32'(v.rt);
    for (int h = 0; h <= last_row; h++) begin
      for (int c = 0; c < v.q; c++) begin
        for (int wi = 0; wi < v.s; wi++) begin
          col = wi + v.u * v.iter;
          pd  = (h < v.pad) || (h >= v.hw + v.pad) || (col < v.pad) || (col >= v.hw + v.pad);
          addr = ((v.cb + c) * v.hw * v.hw + (h - v.pad) * v.hw + (col - v.pad)) & 16'hFFFF;
          hp1 = h + 1;
          w.tag = {rtv[RTW-1:0], hp1[CTW-1:0]};
          w.pad = pd;
          if (!pd) begin
            aq.push_back(addr);
            w.data = mem_word(addr[AW-1:0]);
            wq.push_back(w);
          end else if (v.mode == int'(PAD_EMIT)) begin
            w.data = '0;
            wq.push_back(w);
          end
        end
      end
    end
  endtask

  task automatic apply_cfg(input vec_t v);
    layer_hw  = 8'(v.hw);
    layer_u   = 3'(v.u);
    layer_pad = 2'(v.pad);
    layer_e   = 5'(v.e);
    layer_q   = 3'(v.q);
    layer_s   = 4'(v.s);
    iter_cnt  = 6'(v.iter);
    c_base    = 8'(v.cb);
    row_tag   = 4'(v.rt);
    pad_mode  = 1'(v.mode);
  endtask

  task automatic run_pass(input vec_t v, input bit inj);
    int n;
    build_model(v);
    clear_stats();
    rmode  = v.rmode;
    inject = inj;
    apply_cfg(v);
    start = 1'b1;
    step();
    check("busy_after_start", int'(busy), 1);
    // Configuration is latched; scramble the inputs for the rest of the pass.
    layer_hw = 8'($urandom); layer_u = 3'($urandom); layer_pad = 2'($urandom);
    layer_s = 4'($urandom); c_base = 8'($urandom); row_tag = 4'($urandom);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      step();
      n++;
    end
    check("done_seen", done_cnt, 1);
    check("word_count", recv, v.exp_words);
    check("scoreboard_empty", wq.size(), 0);
    check("addr_queue_empty", aq.size(), 0);
    if (v.exp_words > 0) check("done_latency", done_cyc - last_xfer, 1);
    if (v.exp_addr0 >= 0) check("first_addr", first_addr, v.exp_addr0);
    step();
    step();
    check("idle_after_done", int'(busy), 0);
    check("done_single_pulse", done_cnt, 1);
    inject = 0;
  endtask

  vec_t vecs[7];
  vec_t stall_v, rst_v;

  initial begin
    //          hw u pad e q s it cb rt md rm words addr0
    vecs[0] = '{8, 1, 0, 2, 1, 3, 0, 0, 5, 0, 0, 12, 0};
    vecs[1] = '{8, 1, 1, 2, 1, 3, 0, 0, 6, 0, 0, 6, 0};
    vecs[2] = '{8, 1, 1, 2, 1, 3, 0, 0, 7, 1, 0, 12, 0};
    vecs[3] = '{4, 1, 0, 1, 2, 1, 0, 3, 9, 0, 0, 2, 48};
    vecs[4] = '{4, 1, 1, 1, 1, 1, 0, 0, 2, 0, 0, 0, -1};
    vecs[5] = '{8, 2, 1, 3, 2, 3, 2, 1, 11, 1, 1, 42, 67};
    vecs[6] = '{8, 2, 1, 2, 1, 3, 4, 0, 3, 0, 1, 4, 7};
    stall_v = '{8, 1, 0, 4, 1, 3, 0, 0, 12, 0, 2, 18, 0};
    rst_v   = '{4, 1, 0, 1, 2, 1, 0, 3, 9, 0, 3, 2, 48};

    rst_n = 1'b0; start = 1'b0; ifmap_ready = 1'b1;
    apply_cfg(vecs[0]);
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(ifmap_valid), 0);
    check("reset_glb_en", int'(glb_en), 0);
    check("reset_done", int'(done), 0);

    for (int i = 0; i < 7; i++) run_pass(vecs[i], i == 5);

    // Long downstream stall: credit caps outstanding reads and holds the head stable.
    run_pass(stall_v, 1'b0);
    check("stall_outstanding", stall_outstanding, DEPTH);
    check("stall_late_en", stall_late_en, 0);

    // Reset in DRAIN with words parked in the FIFO.
    build_model(rst_v);
    clear_stats();
    rmode = rst_v.rmode;
    apply_cfg(rst_v);
    start = 1'b1;
    repeat (8) step();
    check("pre_reset_valid", int'(ifmap_valid), 1);
    check("pre_reset_busy", int'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(ifmap_valid), 0);
    check("rst_glb_en", int'(glb_en), 0);
    check("rst_glb_ra", int'(glb_ra), 0);
    check("rst_data", int'(ifmap_data), 0);
    check("rst_tag", int'(ifmap_tag), 0);
    stall_prev = 0;
    repeat (3) step();
    check("rst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    run_pass(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
